// File: rtl/stream_bram_loader.sv
`default_nettype none
// ============================================================================
//  Module      : stream_bram_loader
//  Description : Accepts a load descriptor (target SRAM, byte base address,
//                word count) and copies an AXI-stream payload into either the
//                feature-SRAM or kernel-SRAM BRAM-controller port, one word
//                per cycle. Flags streams that end early or run late.
//  Revision    : 1.0  initial release
// ============================================================================
module stream_bram_loader #(
    parameter int DATA_WIDTH   = 32,
    parameter int FRAM_BADDR_W = 16,
    parameter int KRAM_BADDR_W = 16,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    // Load descriptor
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic                    cfg_target,
    input  logic [31:0]             cfg_baseaddr,
    input  logic [CNT_W-1:0]        cfg_words,
    // Load data stream
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic                    s_tvalid,
    input  logic                    s_tlast,
    output logic                    s_tready,
    // Feature-SRAM port
    output logic [FRAM_BADDR_W-1:0] fram_addr_byteidx,
    output logic [DATA_WIDTH-1:0]   fram_wdata,
    output logic                    fram_we,
    output logic                    fram_en,
    // Kernel-SRAM port
    output logic [KRAM_BADDR_W-1:0] kram_addr_byteidx,
    output logic [DATA_WIDTH-1:0]   kram_wdata,
    output logic                    kram_we,
    output logic                    kram_en,
    // Status
    output logic                    busy,
    output logic                    done,
    output logic                    err_early,
    output logic                    err_late,
    output logic [CNT_W-1:0]        words_written
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                  r_state;
    state_t                  w_state_next;

    logic                    r_target;
    logic [31:0]             r_base;
    logic [CNT_W-1:0]        r_words;
    logic [CNT_W-1:0]        r_words_written;
    logic                    r_err_early;
    logic                    r_err_late;

    // Registered write presented to the SRAM ports one cycle after a beat
    logic                    r_wr_valid;
    logic                    r_wr_target;
    logic [31:0]             r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_wr_data;

    logic                    w_cfg_accept;
    logic                    w_load_beat;
    logic                    w_last_idx;
    logic [31:0]             w_beat_addr;
    logic                    w_unused_ok;

    assign w_cfg_accept = (r_state == ST_IDLE) && cfg_valid;
    assign w_load_beat  = (r_state == ST_LOAD) && s_tvalid;
    // The running write count doubles as the beat index while loading
    assign w_last_idx   = (r_words_written == (r_words - c_cnt_one));
    assign w_beat_addr  = r_base + 32'({r_words_written, 2'b00});

    // Upper address bits beyond the port widths are intentionally dropped
    assign w_unused_ok  = &{1'b0, r_wr_addr, w_beat_addr};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake/status outputs
    always_comb begin
        w_state_next = r_state;
        cfg_ready    = 1'b0;
        s_tready     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_valid) begin
                    w_state_next = (cfg_words == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_tready = 1'b1;
                if (s_tvalid) begin
                    if (s_tlast) begin
                        w_state_next = ST_DONE;
                    end else if (w_last_idx) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                s_tready = 1'b1;
                if (s_tvalid && s_tlast) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Hold off the pulse while the final write is still on the port
                if (!r_wr_valid) begin
                    done         = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Descriptor capture, write pipeline, word counter and error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target        <= 1'b0;
            r_base          <= '0;
            r_words         <= '0;
            r_words_written <= '0;
            r_err_early     <= 1'b0;
            r_err_late      <= 1'b0;
            r_wr_valid      <= 1'b0;
            r_wr_target     <= 1'b0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
        end else begin
            r_wr_valid <= 1'b0;
            if (w_cfg_accept) begin
                r_target        <= cfg_target;
                r_base          <= {cfg_baseaddr[31:2], 2'b00};
                r_words         <= cfg_words;
                r_words_written <= '0;
                r_err_early     <= 1'b0;
                r_err_late      <= 1'b0;
            end
            if (w_load_beat) begin
                r_wr_valid      <= 1'b1;
                r_wr_target     <= r_target;
                r_wr_addr       <= w_beat_addr;
                r_wr_data       <= s_tdata;
                r_words_written <= r_words_written + c_cnt_one;
                if (s_tlast && !w_last_idx) begin
                    r_err_early <= 1'b1;
                end
                if (!s_tlast && w_last_idx) begin
                    r_err_late <= 1'b1;
                end
            end
        end
    end

    assign fram_en           = r_wr_valid && !r_wr_target;
    assign fram_we           = r_wr_valid && !r_wr_target;
    assign fram_addr_byteidx = r_wr_addr[FRAM_BADDR_W-1:0];
    assign fram_wdata        = r_wr_data;

    assign kram_en           = r_wr_valid && r_wr_target;
    assign kram_we           = r_wr_valid && r_wr_target;
    assign kram_addr_byteidx = r_wr_addr[KRAM_BADDR_W-1:0];
    assign kram_wdata        = r_wr_data;

    assign err_early         = r_err_early;
    assign err_late          = r_err_late;
    assign words_written     = r_words_written;

endmodule
`default_nettype wire
